mem_arbiter: RTL and testbench



---
 rtl/chip8_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 widths, arbiter state codes, port ids and memory map.
// No ports; imported by the arbiter top and its winner-select sub-module.
package chip8_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_ISSUE = 2'd1;
    localparam logic [1:0] ST_RD_WAIT  = 2'd2;
    localparam logic [1:0] ST_WR_ISSUE = 2'd3;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_DISP = 1'b1
    } port_id_e;

    localparam logic [11:0] STACK_BASE = 12'h000;
    localparam logic [11:0] REG_BASE   = 12'h020;
    localparam logic [11:0] VF_ADDR    = 12'h02F;
    localparam logic [11:0] FB_BASE    = 12'h100;
    localparam logic [11:0] FB_SIZE    = 12'h100;
    localparam logic [11:0] PROG_BASE  = 12'h200;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both requester handshakes and the memory strobe bus.
// Ports: none; modport slave is the arbiter's view, master the requesters'/memory's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_read_idx;
    logic [DATA_W-1:0] mem_read_byte;
    logic              mem_read_ack;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_write_idx;
    logic [DATA_W-1:0] mem_write_byte;
    logic              timeout_err;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata,
        output mem_read, mem_read_idx,
        input  mem_read_byte, mem_read_ack,
        output mem_write, mem_write_idx, mem_write_byte,
        output timeout_err
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata,
        input  mem_read, mem_read_idx,
        output mem_read_byte, mem_read_ack,
        input  mem_write, mem_write_idx, mem_write_byte,
        input  timeout_err
    );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way winner select, round-robin or port-0 fixed priority.
// Ports: req0_i/req1_i requests, last_i previously served port, gnt_o winning port
// (only meaningful when at least one request is high).
module rr_pick2
    import chip8_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic     req0_i,
    input  logic     req1_i,
    input  port_id_e last_i,
    output port_id_e gnt_o
);

    // On contention round-robin hands the grant to whichever port was not served last.
    assign gnt_o = (req0_i && req1_i)
                 ? ((FIXED_PRIO != 0 || last_i == PORT_DISP) ? PORT_CPU : PORT_DISP)
                 : (req1_i ? PORT_DISP : PORT_CPU);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port CHIP-8 memory between the CPU (port 0) and display (port 1).
// Ports: clk, rst_n (sync, active-low); bus (mem_arbiter_if.slave) carrying both requester
// req/we/addr/wdata -> ack/rdata handshakes, the memory read/write strobe bus and timeout_err.
module mem_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIXED_PRIO  = 0,
    parameter int ACK_TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    logic [1:0]        state_q, state_d;
    port_id_e          owner_q, owner_d;
    port_id_e          last_q, last_d;
    port_id_e          gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              sel_we;
    logic              rd_done;
    logic              rd_abort;
    logic              ack;

    rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req0_i (bus.p0_req),
        .req1_i (bus.p1_req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign sel_we   = gnt == PORT_DISP ? bus.p1_we : bus.p0_we;
    assign rd_done  = state_q == ST_RD_WAIT && bus.mem_read_ack;
    // The counter holds the number of ack-less wait cycles already spent, so the
    // abort lands on the wait cycle where it would reach ACK_TIMEOUT.
    assign rd_abort = state_q == ST_RD_WAIT && !bus.mem_read_ack && cnt_q == 8'(ACK_TIMEOUT - 1);
    assign ack      = rd_done || rd_abort || state_q == ST_WR_ISSUE;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (bus.p0_req || bus.p1_req) begin
                owner_d = gnt;
                addr_d  = gnt == PORT_DISP ? bus.p1_addr : bus.p0_addr;
                wdata_d = gnt == PORT_DISP ? bus.p1_wdata : bus.p0_wdata;
                state_d = sel_we ? ST_WR_ISSUE : ST_RD_ISSUE;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
                cnt_d   = '0;
            end
            ST_RD_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (rd_done || rd_abort) ? ST_IDLE : ST_RD_WAIT;
                last_d  = rd_done ? owner_q : last_q;
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_CPU;
            last_q  <= PORT_DISP;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_read       = state_q == ST_RD_ISSUE;
    assign bus.mem_read_idx   = addr_q;
    assign bus.mem_write      = state_q == ST_WR_ISSUE;
    assign bus.mem_write_idx  = addr_q;
    assign bus.mem_write_byte = wdata_q;
    assign bus.timeout_err    = rd_abort;
    assign bus.p0_ack         = ack && owner_q == PORT_CPU;
    assign bus.p1_ack         = ack && owner_q == PORT_DISP;
    assign bus.p0_rdata       = rd_abort ? '0 : bus.mem_read_byte;
    assign bus.p1_rdata       = rd_abort ? '0 : bus.mem_read_byte;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (round-robin and fixed-priority instances).
module tb_mem_arbiter;

    typedef struct {
        bit         port;
        bit         we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } vec_t;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   hold_ack = 1'b0;
    bit   inject = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   written[4096];
    logic [7:0] store[4096];

    always #5 clk = ~clk;

    mem_arbiter_if a ();
    mem_arbiter_if f ();

    mem_arbiter u_rr (.clk(clk), .rst_n(rst_n), .bus(a));
    mem_arbiter #(.FIXED_PRIO(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(f));

    function automatic logic [7:0] init_byte(input logic [11:0] ad);
        return ad == 12'h200 ? 8'h12 : ad[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        a.mem_read_ack  <= (a.mem_read && !hold_ack) || inject;
        a.mem_read_byte <= written[a.mem_read_idx] ? store[a.mem_read_idx] : init_byte(a.mem_read_idx);
        if (a.mem_write) begin
            written[a.mem_write_idx] <= 1'b1;
            store[a.mem_write_idx]   <= a.mem_write_byte;
        end
        f.mem_read_ack  <= f.mem_read;
        f.mem_read_byte <= init_byte(f.mem_read_idx);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xact(input vec_t v);
        int   lat = 0;
        bit   got = 1'b0;
        exp_t e;
        sb.push_back('{v.port, v.we, v.rdata});
        if (v.port) begin
            a.p1_req = 1'b1; a.p1_we = v.we; a.p1_addr = v.addr; a.p1_wdata = v.wdata;
        end else begin
            a.p0_req = 1'b1; a.p0_we = v.we; a.p0_addr = v.addr; a.p0_wdata = v.wdata;
        end
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !v.we) check("rd_strobe", {a.mem_read, a.mem_read_idx}, {1'b1, v.addr});
            got = a.p0_ack || a.p1_ack;
        end
        if (!got) begin
            check("ack_seen", 0, 1);
        end else begin
            e = sb.pop_front();
            check("ack_port", {a.p0_ack, a.p1_ack}, e.port ? 2'b01 : 2'b10);
            check("latency", lat, e.we ? 1 : 2);
            if (e.we) check("wr_bus", {a.mem_write, a.mem_write_idx, a.mem_write_byte}, {1'b1, v.addr, v.wdata});
            else check("rdata", e.port ? a.p1_rdata : a.p0_rdata, e.rdata);
        end
        a.p0_req = 1'b0;
        a.p1_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[9];
        exp_t e;
        int   lat;
        int   terr;
        int   n;
        int   cyc;
        int   prev;
        bit   got;
        vecs[0] = '{1'b0, 1'b0, 12'h200, 8'h00, 8'h12};
        vecs[1] = '{1'b1, 1'b1, 12'h105, 8'hAA, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 12'h105, 8'h00, 8'hAA};
        vecs[3] = '{1'b1, 1'b0, 12'h100, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 1'b1, 12'h020, 8'h77, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 12'h020, 8'h00, 8'h77};
        vecs[6] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'hA5};
        vecs[7] = '{1'b0, 1'b1, 12'h000, 8'h01, 8'h00};
        vecs[8] = '{1'b0, 1'b0, 12'h000, 8'h00, 8'h01};
        {a.p0_req, a.p0_we, a.p0_addr, a.p0_wdata} = '0;
        {a.p1_req, a.p1_we, a.p1_addr, a.p1_wdata} = '0;
        {f.p0_req, f.p0_we, f.p0_addr, f.p0_wdata} = '0;
        {f.p1_req, f.p1_we, f.p1_addr, f.p1_wdata} = '0;
        repeat (3) @(negedge clk);
        check("rst_strobes_rr", {a.p0_ack, a.p1_ack, a.mem_read, a.mem_write, a.timeout_err}, 0);
        check("rst_buses_rr", {a.mem_read_idx, a.mem_write_idx, a.mem_write_byte}, 0);
        check("rst_strobes_fp", {f.p0_ack, f.p1_ack, f.mem_read, f.mem_write, f.timeout_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) xact(vecs[i]);

        // Watchdog: p1 read with the memory ack withheld, then a late ack while idle.
        hold_ack = 1'b1;
        a.p1_req = 1'b1; a.p1_we = 1'b0; a.p1_addr = 12'h130;
        sb.push_back('{1'b1, 1'b0, 8'h00});
        lat = 0; terr = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            terr += int'(a.timeout_err);
            got = a.p0_ack || a.p1_ack;
        end
        if (!got) check("to_ack_seen", 0, 1);
        else begin
            e = sb.pop_front();
            check("to_port", {a.p0_ack, a.p1_ack}, e.port ? 2'b01 : 2'b10);
            check("to_latency", lat, 16);
            check("to_rdata", a.p1_rdata, e.rdata);
            check("to_err_pulses", terr, 1);
        end
        a.p1_req = 1'b0;
        hold_ack = 1'b0;
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check("late_ack_ignored", {a.p0_ack, a.p1_ack, a.timeout_err}, 0);
        repeat (2) @(negedge clk);

        // Reset while in RD_WAIT, then both ports hold reads: strict alternation from p0.
        hold_ack = 1'b1;
        a.p1_req = 1'b1; a.p1_we = 1'b0; a.p1_addr = 12'h140;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        a.p1_req = 1'b0;
        @(negedge clk);
        check("midrst_strobes", {a.p0_ack, a.p1_ack, a.mem_read, a.mem_write, a.timeout_err}, 0);
        rst_n = 1'b1;
        hold_ack = 1'b0;
        for (int k = 0; k < 6; k++) sb.push_back('{k[0], 1'b0, k[0] ? 8'h5A : 8'h77});
        a.p0_req = 1'b1; a.p0_we = 1'b0; a.p0_addr = 12'h020;
        a.p1_req = 1'b1; a.p1_we = 1'b0; a.p1_addr = 12'h100;
        n = 0; cyc = 0; prev = 0;
        while (n < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (a.p0_ack || a.p1_ack) begin
                e = sb.pop_front();
                check("alt_port", {a.p0_ack, a.p1_ack}, e.port ? 2'b01 : 2'b10);
                check("alt_rdata", e.port ? a.p1_rdata : a.p0_rdata, e.rdata);
                check("alt_spacing", cyc - prev, n == 0 ? 2 : 3);
                prev = cyc;
                n++;
            end
        end
        check("alt_count", n, 6);
        a.p0_req = 1'b0;
        a.p1_req = 1'b0;
        sb.delete();
        @(negedge clk);

        // Fixed priority: p0 keeps winning while held; p1 only after p0 drops.
        for (int k = 0; k < 3; k++) sb.push_back('{1'b0, 1'b0, 8'h7A});
        sb.push_back('{1'b1, 1'b0, 8'h5A});
        f.p0_req = 1'b1; f.p0_we = 1'b0; f.p0_addr = 12'h020;
        f.p1_req = 1'b1; f.p1_we = 1'b0; f.p1_addr = 12'h100;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (f.p0_ack || f.p1_ack) begin
                e = sb.pop_front();
                check("fp_port", {f.p0_ack, f.p1_ack}, e.port ? 2'b01 : 2'b10);
                check("fp_rdata", e.port ? f.p1_rdata : f.p0_rdata, e.rdata);
                n++;
                if (n == 3) f.p0_req = 1'b0;
                if (n == 4) f.p1_req = 1'b0;
            end
        end
        check("fp_count", n, 4);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
